// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: FSM states, opcode/funct
// values, datapath select codes and the bundled control word.
package mc_pkg;

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_EXE     = 4'd2;
  localparam logic [3:0] S_ALU_WB  = 4'd3;
  localparam logic [3:0] S_MEM_ADR = 4'd4;
  localparam logic [3:0] S_MEM_RD  = 4'd5;
  localparam logic [3:0] S_MEM_WB  = 4'd6;
  localparam logic [3:0] S_MEM_WR  = 4'd7;
  localparam logic [3:0] S_BRANCH  = 4'd8;
  localparam logic [3:0] S_JUMP    = 4'd9;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_SLT = 3'b011;
  localparam logic [2:0] ALU_LUI = 3'b100;

  localparam logic [1:0] EXT_ZERO  = 2'b00;
  localparam logic [1:0] EXT_SIGN  = 2'b01;
  localparam logic [1:0] EXT_UPPER = 2'b10;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;

  localparam logic [1:0] RD_RT  = 2'b00;
  localparam logic [1:0] RD_RD  = 2'b01;
  localparam logic [1:0] RD_OVF = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MDR = 2'b01;
  localparam logic [1:0] WB_ONE = 2'b10;

  localparam logic [1:0] SB_B      = 2'b00;
  localparam logic [1:0] SB_FOUR   = 2'b01;
  localparam logic [1:0] SB_IMM    = 2'b10;
  localparam logic [1:0] SB_IMM_SH = 2'b11;

  typedef enum logic [2:0] {
    CL_NOP, CL_ALU, CL_LW, CL_SW, CL_BEQ, CL_J
  } iclass_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_src;
    logic       ir_write;
    logic [1:0] reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic [2:0] alu_op;
    logic [1:0] ext_op;
    logic       wr_gpr30;
  } ctrl_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: opcode/funct -> class plus the ALU
// operation and immediate extension used in the EXE state.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output iclass_e    cls_o,
  output logic       rtype_o,
  output logic       add_ovf_o,
  output logic [2:0] alu_op_o,
  output logic [1:0] ext_op_o
);

  always_comb begin
    cls_o     = CL_NOP;
    rtype_o   = (opcode_i == OP_RTYPE);
    add_ovf_o = 1'b0;
    alu_op_o  = ALU_ADD;
    ext_op_o  = EXT_ZERO;
    case (opcode_i)
      OP_RTYPE: begin
        // unsupported funct codes fall through as NOP
        case (funct_i)
          FN_ADD:  begin cls_o = CL_ALU; add_ovf_o = 1'b1; end
          FN_ADDU: cls_o = CL_ALU;
          FN_SUBU: begin cls_o = CL_ALU; alu_op_o = ALU_SUB; end
          FN_SLT:  begin cls_o = CL_ALU; alu_op_o = ALU_SLT; end
          default: cls_o = CL_NOP;
        endcase
      end
      OP_ORI:  begin cls_o = CL_ALU; alu_op_o = ALU_OR; end
      OP_LUI:  begin cls_o = CL_ALU; alu_op_o = ALU_LUI; ext_op_o = EXT_UPPER; end
      OP_ADDI: begin cls_o = CL_ALU; ext_op_o = EXT_SIGN; add_ovf_o = 1'b1; end
      OP_LW:   cls_o = CL_LW;
      OP_SW:   cls_o = CL_SW;
      OP_BEQ:  cls_o = CL_BEQ;
      OP_J:    cls_o = CL_J;
      default: cls_o = CL_NOP;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore FSM driving the multi-cycle MIPS datapath enables and mux selects.
// Define MC_OVF_GPR30_EN to redirect add/addi overflow results into GPR_OVF_IDX.
module multicycle_ctrl
  import mc_pkg::*;
#(
  parameter int unsigned GPR_OVF_IDX = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       overflow,
  input  logic       dm_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic [1:0] PCSrc,
  output logic       IRWrite,
  output logic [1:0] RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] MemtoReg,
  output logic       MemRead,
  output logic       MemWrite,
  output logic [2:0] ALUOp,
  output logic [1:0] ExtOp,
  output logic       WriteToGPR_30,
  output logic [3:0] state
);

  logic [3:0] state_q, state_d;
  iclass_e    cls;
  logic       rtype, add_ovf, ovf_wb;
  logic [2:0] exe_alu_op;
  logic [1:0] exe_ext_op;
  ctrl_t      c, o;
  logic       unused_sink;

  mc_decode u_decode (
    .opcode_i  (opcode),
    .funct_i   (funct),
    .cls_o     (cls),
    .rtype_o   (rtype),
    .add_ovf_o (add_ovf),
    .alu_op_o  (exe_alu_op),
    .ext_op_o  (exe_ext_op)
  );

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (cls)
          CL_ALU:        state_d = S_EXE;
          CL_LW, CL_SW:  state_d = S_MEM_ADR;
          CL_BEQ:        state_d = S_BRANCH;
          CL_J:          state_d = S_JUMP;
          default:       state_d = S_FETCH;
        endcase
      end
      S_EXE:     state_d = S_ALU_WB;
      S_MEM_ADR: state_d = (cls == CL_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:  state_d = dm_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR:  state_d = dm_ready ? S_FETCH : S_MEM_WR;
      default:   state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

`ifdef MC_OVF_GPR30_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (state_q == S_FETCH)    ovf_d = 1'b0;
    else if (state_q == S_EXE) ovf_d = overflow;
  end

  always_ff @(posedge clk) begin
    if (reset) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  // index 0 is the hardwired zero register, so redirecting there is pointless
  assign ovf_wb      = ovf_q & add_ovf & (GPR_OVF_IDX != 32'd0);
  assign unused_sink = zero;
`else
  assign ovf_wb      = 1'b0;
  assign unused_sink = ^{zero, overflow, add_ovf, 5'(GPR_OVF_IDX)};
`endif

  always_comb begin
    c = '0;
    case (state_q)
      S_FETCH: begin
        c.ir_write  = 1'b1;
        c.pc_write  = 1'b1;
        c.alu_src_b = SB_FOUR;
        c.alu_op    = ALU_ADD;
        c.pc_src    = PC_SEQ;
      end
      S_DECODE: begin
        c.alu_src_b = SB_IMM_SH;
        c.ext_op    = EXT_SIGN;
      end
      S_EXE: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = rtype ? SB_B : SB_IMM;
        c.alu_op    = exe_alu_op;
        c.ext_op    = exe_ext_op;
      end
      S_ALU_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = ovf_wb ? WB_ONE : WB_ALU;
        c.reg_dst    = ovf_wb ? RD_OVF : (rtype ? RD_RD : RD_RT);
        c.wr_gpr30   = ovf_wb;
      end
      S_MEM_ADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SB_IMM;
        c.ext_op    = EXT_SIGN;
        c.alu_op    = ALU_ADD;
      end
      S_MEM_RD: c.mem_read = 1'b1;
      S_MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = WB_MDR;
        c.reg_dst    = RD_RT;
      end
      S_MEM_WR: c.mem_write = 1'b1;
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_src_b     = SB_B;
        c.alu_op        = ALU_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_src        = PC_BR;
      end
      S_JUMP: begin
        c.pc_write = 1'b1;
        c.pc_src   = PC_JMP;
      end
      default: c = '0;
    endcase
    o = reset ? '0 : c;
  end

  assign PCWrite       = o.pc_write;
  assign PCWriteCond   = o.pc_write_cond;
  assign PCSrc         = o.pc_src;
  assign IRWrite       = o.ir_write;
  assign RegDst        = o.reg_dst;
  assign RegWrite      = o.reg_write;
  assign ALUSrcA       = o.alu_src_a;
  assign ALUSrcB       = o.alu_src_b;
  assign MemtoReg      = o.mem_to_reg;
  assign MemRead       = o.mem_read;
  assign MemWrite      = o.mem_write;
  assign ALUOp         = o.alu_op;
  assign ExtOp         = o.ext_op;
  assign WriteToGPR_30 = o.wr_gpr30;
  assign state         = reset ? S_FETCH : state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Instruction-level model of the multi-cycle controller: each instruction is
// expanded into its phase sequence and every cycle's outputs are compared.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset, zero, overflow, dm_ready;
  logic [5:0] opcode, funct;
  logic       PCWrite, PCWriteCond, IRWrite, RegWrite, ALUSrcA, MemRead, MemWrite, WriteToGPR_30;
  logic [1:0] PCSrc, RegDst, ALUSrcB, MemtoReg, ExtOp;
  logic [2:0] ALUOp;
  logic [3:0] state;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .overflow(overflow), .dm_ready(dm_ready), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .PCSrc(PCSrc), .IRWrite(IRWrite), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .MemtoReg(MemtoReg), .MemRead(MemRead),
    .MemWrite(MemWrite), .ALUOp(ALUOp), .ExtOp(ExtOp), .WriteToGPR_30(WriteToGPR_30),
    .state(state)
  );

  always #5 clk = ~clk;

`ifdef MC_OVF_GPR30_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  localparam logic [5:0] R = 6'h00, ORI = 6'h0d, LUI = 6'h0f, ADDI = 6'h08;
  localparam logic [5:0] LW = 6'h23, SW = 6'h2b, BEQ = 6'h04, JMP = 6'h02;
  localparam logic [5:0] F_ADD = 6'h20, F_ADDU = 6'h21, F_SUBU = 6'h23, F_SLT = 6'h2a;

  typedef enum int {PH_F, PH_D, PH_EXE, PH_AWB, PH_ADR, PH_RD, PH_MWB, PH_WR, PH_BR, PH_J} ph_e;

  typedef struct packed {
    logic pcw, pcwc; logic [1:0] pcsrc; logic irw; logic [1:0] regdst; logic regw, srca;
    logic [1:0] srcb, m2r; logic mrd, mwr; logic [2:0] aluop; logic [1:0] extop; logic wr30;
  } ov_t;
  typedef struct packed { logic rst; ov_t v; } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  ov_t  act;
  int   tests = 0, fails = 0;
  logic [5:0] cur_op, cur_fn;
  logic       cur_ovf, cur_z;

  assign act = {PCWrite, PCWriteCond, PCSrc, IRWrite, RegDst, RegWrite, ALUSrcA, ALUSrcB,
                MemtoReg, MemRead, MemWrite, ALUOp, ExtOp, WriteToGPR_30};

  function automatic bit alu_class(logic [5:0] op, logic [5:0] fn);
    return (op == R && (fn == F_ADD || fn == F_ADDU || fn == F_SUBU || fn == F_SLT)) ||
           op == ORI || op == LUI || op == ADDI;
  endfunction

  // expected outputs for one phase of an instruction
  function automatic ov_t model(ph_e ph, logic [5:0] op, logic [5:0] fn, logic ovf);
    ov_t o = '0;
    bit  r = (op == R);
    case (ph)
      PH_F:   begin o.pcw = 1; o.irw = 1; o.srcb = 2'b01; end
      PH_D:   begin o.srcb = 2'b11; o.extop = 2'b01; end
      PH_EXE: begin
        o.srca = 1; o.srcb = r ? 2'b00 : 2'b10;
        if (r)              o.aluop = (fn == F_SUBU) ? 3'd1 : (fn == F_SLT) ? 3'd3 : 3'd0;
        else if (op == ORI) o.aluop = 3'd2;
        else if (op == LUI) begin o.aluop = 3'd4; o.extop = 2'b10; end
        else                o.extop = 2'b01;
      end
      PH_AWB: begin
        o.regw = 1; o.regdst = r ? 2'b01 : 2'b00;
        if (OVF_EN && ovf && ((r && fn == F_ADD) || op == ADDI)) begin
          o.regdst = 2'b10; o.m2r = 2'b10; o.wr30 = 1;
        end
      end
      PH_ADR: begin o.srca = 1; o.srcb = 2'b10; o.extop = 2'b01; end
      PH_RD:  o.mrd = 1;
      PH_MWB: begin o.regw = 1; o.m2r = 2'b01; end
      PH_WR:  o.mwr = 1;
      PH_BR:  begin o.srca = 1; o.aluop = 3'd1; o.pcwc = 1; o.pcsrc = 2'b01; end
      PH_J:   begin o.pcw = 1; o.pcsrc = 2'b10; end
      default: o = '0;
    endcase
    return o;
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      tests++;
      if (act !== cur.v || (cur.rst && state !== 4'd0)) begin
        fails++;
        $display("FAIL cycle_outputs t=%0t got=%h state=%0d expected=%h rst=%0b",
                 $time, act, state, cur.v, cur.rst);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic cyc(input logic r, input logic d, input logic o, input logic z, input exp_t e);
    reset = r; dm_ready = d; overflow = o; zero = z;
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic rst_cycle();
    exp_t e;
    e.rst = 1'b1; e.v = '0;
    cyc(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), e);
  endtask

  task automatic set_instr(input logic [5:0] op, input logic [5:0] fn, input logic ovf, input logic z);
    cur_op = op; cur_fn = fn; cur_ovf = ovf; cur_z = z;
  endtask

  task automatic step(input ph_e ph, input logic d);
    exp_t e;
    logic o, z;
    o = (ph == PH_EXE) ? cur_ovf : 1'($urandom);
    z = (ph == PH_BR) ? cur_z : 1'($urandom);
    // opcode/funct only have to be valid from DECODE on
    if (ph == PH_F) begin opcode = 6'($urandom); funct = 6'($urandom); end
    e.rst = 1'b0; e.v = model(ph, cur_op, cur_fn, cur_ovf);
    cyc(1'b0, d, o, z, e);
    if (ph == PH_F) begin opcode = cur_op; funct = cur_fn; end
  endtask

  task automatic run_instr(input int stalls);
    step(PH_F, 1'($urandom));
    step(PH_D, 1'($urandom));
    if (alu_class(cur_op, cur_fn)) begin
      step(PH_EXE, 1'($urandom)); step(PH_AWB, 1'($urandom));
    end else if (cur_op == LW) begin
      step(PH_ADR, 1'($urandom));
      repeat (stalls) step(PH_RD, 1'b0);
      step(PH_RD, 1'b1); step(PH_MWB, 1'($urandom));
    end else if (cur_op == SW) begin
      step(PH_ADR, 1'($urandom));
      repeat (stalls) step(PH_WR, 1'b0);
      step(PH_WR, 1'b1);
    end else if (cur_op == BEQ) step(PH_BR, 1'($urandom));
    else if (cur_op == JMP)     step(PH_J, 1'($urandom));
  endtask

  initial begin
    logic [5:0] op, fn;
    reset = 1'b1; zero = 0; overflow = 0; dm_ready = 0; opcode = 0; funct = 0;
    @(posedge clk); #1;
    rst_cycle();
    chk("reset_all_zero", {7'd0, act, state}, 32'd0);
    rst_cycle();
    reset = 1'b0; #1;
    chk("post_reset_fetch", {PCWrite, IRWrite, ALUSrcA, ALUSrcB, ALUOp}, 8'b11001000);

    // addu: 4 cycles
    set_instr(R, F_ADDU, 1'b0, 1'b0);
    step(PH_F, 1'b1); step(PH_D, 1'b1);
    chk("addu_exe", {ALUSrcA, ALUSrcB, ALUOp}, 6'b100000);
    step(PH_EXE, 1'b1);
    chk("addu_wb", {RegWrite, RegDst, MemtoReg}, 5'b10100);
    step(PH_AWB, 1'b1);
    chk("addu_back_to_fetch", IRWrite, 1);

    // lw with 3 stall cycles: 8 cycles
    set_instr(LW, 6'h15, 1'b0, 1'b0);
    step(PH_F, 1'b1); step(PH_D, 1'b1); step(PH_ADR, 1'b1);
    chk("lw_memread", MemRead, 1);
    repeat (3) step(PH_RD, 1'b0);
    step(PH_RD, 1'b1);
    chk("lw_mem_wb", {RegWrite, MemtoReg, RegDst, MemRead}, 6'b101000);
    step(PH_MWB, 1'b1);
    chk("lw_back_to_fetch", IRWrite, 1);

    // beq taken and not taken
    for (int z = 1; z >= 0; z--) begin
      set_instr(BEQ, 6'h00, 1'b0, 1'(z));
      step(PH_F, 1'b1); step(PH_D, 1'b1);
      chk("beq_branch", {PCWriteCond, PCSrc, ALUOp}, 6'b101001);
      step(PH_BR, 1'b1);
      chk("beq_back_to_fetch", IRWrite, 1);
    end

    // unknown opcode is a 2-cycle NOP
    set_instr(6'h3f, 6'h3f, 1'b0, 1'b0);
    step(PH_F, 1'b1); step(PH_D, 1'b1);
    chk("nop_back_to_fetch", {IRWrite, RegWrite, MemWrite, PCWriteCond}, 4'b1000);

    // add with overflow
    set_instr(R, F_ADD, 1'b1, 1'b0);
    step(PH_F, 1'b1); step(PH_D, 1'b1); step(PH_EXE, 1'b1);
    chk("add_ovf_wb", {RegDst, WriteToGPR_30, MemtoReg}, OVF_EN ? 5'b10110 : 5'b01000);
    step(PH_AWB, 1'b1);

    // reset for 2 cycles while stalled in MEM_WR
    set_instr(SW, 6'h00, 1'b0, 1'b0);
    step(PH_F, 1'b1); step(PH_D, 1'b1); step(PH_ADR, 1'b1);
    step(PH_WR, 1'b0);
    rst_cycle();
    chk("reset_mid_write", {7'd0, act, state}, 32'd0);
    rst_cycle();
    reset = 1'b0; #1;
    chk("fetch_after_mid_reset", {PCWrite, IRWrite, MemWrite, ALUSrcB}, 5'b11001);

    // randomized instruction stream
    for (int n = 0; n < 400; n++) begin
      fn = 6'($urandom);
      case ($urandom_range(0, 12))
        0:  begin op = R; fn = F_ADD;  end
        1:  begin op = R; fn = F_ADDU; end
        2:  begin op = R; fn = F_SUBU; end
        3:  begin op = R; fn = F_SLT;  end
        4:  op = ORI;
        5:  op = LUI;
        6:  op = ADDI;
        7:  op = LW;
        8:  op = SW;
        9:  op = BEQ;
        10: op = JMP;
        11: op = 6'h3f ^ 6'($urandom_range(0, 1));
        default: begin op = R; fn = 6'h00; end
      endcase
      set_instr(op, fn, 1'($urandom), 1'($urandom));
      run_instr($urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
